// File: rtl/viterbi_pkg.sv
// Shared constants, types and branch-metric helper for the rate-1/2 Viterbi ACS scheduler.
// Trellis: K=3, generators G0=111 and G1=101, 4-bit saturating path metrics.
package viterbi_pkg;

    localparam int K          = 3;
    localparam int NUM_STATES = 2 ** (K - 1);
    localparam int W          = 4;

    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;

    typedef enum logic [1:0] {IDLE, ACS, NORM, OUT} state_t;

    typedef logic [W-1:0] pm_t;

    localparam pm_t PM_MAX = '1;

    // Hamming distance between the encoder output for (pred, u) and the received symbol {c0,c1}.
    function automatic logic [1:0] bm(input logic [K-2:0] pred, input logic u, input logic [1:0] sym);
        logic [K-1:0] w_reg;
        logic [1:0]   w_diff;
        w_reg  = {u, pred};
        w_diff = {^(G0 & w_reg), ^(G1 & w_reg)} ^ sym;
        return {1'b0, w_diff[1]} + {1'b0, w_diff[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// Combinational add-compare-select for one next-state: two saturating adds and a tie-to-p0 select.
module viterbi_acs_unit
    import viterbi_pkg::*;
(
    input  pm_t        i_pm0,
    input  pm_t        i_pm1,
    input  logic [1:0] i_bm0,
    input  logic [1:0] i_bm1,
    output pm_t        o_metric,
    output logic       o_surv
);

    logic [W:0] w_sum0;
    logic [W:0] w_sum1;
    pm_t        w_m0;
    pm_t        w_m1;

    assign w_sum0 = {1'b0, i_pm0} + {{(W-1){1'b0}}, i_bm0};
    assign w_sum1 = {1'b0, i_pm1} + {{(W-1){1'b0}}, i_bm1};

    // Carry out of the W-bit add means the metric overflowed, so clamp it.
    assign w_m0 = w_sum0[W] ? PM_MAX : w_sum0[W-1:0];
    assign w_m1 = w_sum1[W] ? PM_MAX : w_sum1[W-1:0];

    assign o_surv   = (w_m1 < w_m0);
    assign o_metric = o_surv ? w_m1 : w_m0;

endmodule

// File: rtl/viterbi_acs_scheduler.sv
// Time-multiplexes one ACS unit across all trellis states per symbol, with ping-pong metric
// banks, per-symbol normalisation, and a registered survivor/best-state output handshake.
module viterbi_acs_scheduler
    import viterbi_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_frame_start,
    input  logic [1:0]              i_sym,
    input  logic                    i_sym_valid,
    output logic                    o_sym_ready,
    output logic [NUM_STATES-1:0]   o_surv,
    output logic [K-2:0]            o_best_state,
    output logic                    o_surv_valid,
    input  logic                    i_surv_ready,
    output logic [NUM_STATES*W-1:0] o_pm
);

    localparam logic [K-2:0] LAST_IDX = {(K-1){1'b1}};

    state_t                r_state;
    state_t                w_next_state;
    logic [K-2:0]          r_idx;
    logic [1:0]            r_sym;
    logic                  r_rd_sel;
    pm_t                   r_bank [2][NUM_STATES];
    logic [NUM_STATES-1:0] r_surv_sr;
    logic [NUM_STATES-1:0] r_surv;
    logic [K-2:0]          r_best;
    logic                  r_surv_valid;

    logic                  w_wr_sel;
    logic                  w_u;
    logic [K-2:0]          w_p0;
    logic [K-2:0]          w_p1;
    pm_t                   w_metric;
    logic                  w_surv_bit;
    pm_t                   w_min;
    logic [K-2:0]          w_best;

    assign w_wr_sel = ~r_rd_sel;
    assign w_u      = r_idx[K-2];
    assign w_p0     = {r_idx[K-3:0], 1'b0};
    assign w_p1     = {r_idx[K-3:0], 1'b1};

    viterbi_acs_unit u_acs (
        .i_pm0    (r_bank[r_rd_sel][w_p0]),
        .i_pm1    (r_bank[r_rd_sel][w_p1]),
        .i_bm0    (bm(w_p0, w_u, r_sym)),
        .i_bm1    (bm(w_p1, w_u, r_sym)),
        .o_metric (w_metric),
        .o_surv   (w_surv_bit)
    );

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_sym_valid) w_next_state = ACS;
            ACS:     if (r_idx == LAST_IDX) w_next_state = NORM;
            NORM:    w_next_state = OUT;
            OUT:     if (r_surv_valid && i_surv_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Strict less-than while scanning upward keeps the lowest index on a tie.
    always_comb begin
        w_min  = PM_MAX;
        w_best = '0;
        for (int s = 0; s < NUM_STATES; s++) begin
            if (r_bank[w_wr_sel][s] < w_min) begin
                w_min  = r_bank[w_wr_sel][s];
                w_best = s[K-2:0];
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_sym        <= '0;
            r_rd_sel     <= 1'b0;
            r_surv_sr    <= '0;
            r_surv       <= '0;
            r_best       <= '0;
            r_surv_valid <= 1'b0;
            // NOTE: the metric banks are a handful of flops, not RAM, so resetting them is cheap and required.
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < NUM_STATES; s++) begin
                    r_bank[b][s] <= (s == 0) ? '0 : PM_MAX;
                end
            end
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    r_idx <= '0;
                    if (i_sym_valid) r_sym <= i_sym;
                    if (i_frame_start) begin
                        for (int s = 0; s < NUM_STATES; s++) begin
                            r_bank[r_rd_sel][s] <= (s == 0) ? '0 : PM_MAX;
                        end
                    end
                end
                ACS: begin
                    r_bank[w_wr_sel][r_idx] <= w_metric;
                    r_surv_sr[r_idx]        <= w_surv_bit;
                    r_idx                   <= r_idx + {{(K-2){1'b0}}, 1'b1};
                end
                NORM: begin
                    for (int s = 0; s < NUM_STATES; s++) begin
                        r_bank[w_wr_sel][s] <= r_bank[w_wr_sel][s] - w_min;
                    end
                    r_rd_sel <= w_wr_sel;
                    r_surv   <= r_surv_sr;
                    r_best   <= w_best;
                end
                OUT: r_surv_valid <= !(r_surv_valid && i_surv_ready);
                default: ;
            endcase
        end
    end

    always_comb begin
        o_pm = '0;
        for (int s = 0; s < NUM_STATES; s++) begin
            o_pm[s*W +: W] = r_bank[r_rd_sel][s];
        end
    end

    assign o_sym_ready  = (r_state == IDLE);
    assign o_surv       = r_surv;
    assign o_best_state = r_best;
    assign o_surv_valid = r_surv_valid;

endmodule
